// File: rtl/mem_access_unit_if.sv
// Interface between the execute stage, the memory access unit, data memory and
// register writeback.
//   ex_*      : execute-result handshake and operands (into the unit)
//   dmem_*    : data-memory req/ack bus (unit is the requester)
//   wb_*      : one-cycle retire pulse towards the register file
//   fault*    : one-cycle exception pulse and its held cause
// Modports: slave = the memory access unit, master = its environment.
interface mem_access_unit_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] alu_result;
  logic [31:0] mem_addr;
  logic [31:0] store_data;
  logic [4:0]  rd;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  logic        wb_valid;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        fault;
  logic [1:0]  fault_cause;

  modport slave (
    input  ex_valid, opcode, funct3, alu_result, mem_addr, store_data, rd,
    input  dmem_ack, dmem_rdata,
    output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output wb_valid, wb_en, wb_rd, wb_data, fault, fault_cause
  );

  modport master (
    output ex_valid, opcode, funct3, alu_result, mem_addr, store_data, rd,
    output dmem_ack, dmem_rdata,
    input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  wb_valid, wb_en, wb_rd, wb_data, fault, fault_cause
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory/writeback stage. Accepts one execute result at a time (ex_ready only in
// IDLE). Non-memory results go straight to writeback; LOAD/STORE run a req/ack
// transaction on the dmem bus with byte-lane steering and load extension.
// Misaligned accesses, illegal widths and memory timeouts raise a one-cycle fault.
// Ports:
//   clk      : clock, all state updates on the rising edge
//   rst      : synchronous active-high reset
//   mau_io   : mem_access_unit_if.slave (execute inputs, dmem bus, writeback, fault)
// Parameter TIMEOUT: number of REQ cycles without ack before a timeout fault (>= 1).
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave mau_io
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  localparam logic [1:0] CauseMisaligned = 2'b01;
  localparam logic [1:0] CauseTimeout    = 2'b10;
  localparam logic [1:0] CauseIllegal    = 2'b11;

  localparam int unsigned   CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWb, StFault} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dmem_we_q, dmem_we_d;
  logic [31:0]     dmem_addr_q, dmem_addr_d;
  logic [31:0]     dmem_wdata_q, dmem_wdata_d;
  logic [3:0]      dmem_wstrb_q, dmem_wstrb_d;
  logic            wb_en_q, wb_en_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic [1:0]      fault_cause_q, fault_cause_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      addr_lo_q, addr_lo_d;

  // Accept-time decode of the incoming execute result.
  logic        is_load, is_store, width_ok, misaligned;
  logic [3:0]  st_strb;
  logic [31:0] st_data;

  always_comb begin
    is_load  = (mau_io.opcode == OpLoad);
    is_store = (mau_io.opcode == OpStore);
    if (is_load) begin
      width_ok = (mau_io.funct3 != 3'b011) && (mau_io.funct3 != 3'b110) &&
                 (mau_io.funct3 != 3'b111);
    end else begin
      width_ok = (mau_io.funct3[2] == 1'b0) && (mau_io.funct3[1:0] != 2'b11);
    end
    // Only meaningful once width_ok holds; funct3[1:0] encodes the size.
    misaligned = ((mau_io.funct3[1:0] == 2'b01) && mau_io.mem_addr[0]) ||
                 ((mau_io.funct3[1:0] == 2'b10) && (mau_io.mem_addr[1:0] != 2'b00));
  end

  // Store lane steering: data replicated across lanes, strobe marks the live bytes.
  always_comb begin
    st_strb = 4'b1111;
    st_data = mau_io.store_data;
    case (mau_io.funct3[1:0])
      2'b00: begin
        st_strb = 4'b0001 << mau_io.mem_addr[1:0];
        st_data = {4{mau_io.store_data[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << {mau_io.mem_addr[1], 1'b0};
        st_data = {2{mau_io.store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction from the returned word using the registered address/width.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    case (addr_lo_q)
      2'd1:    ld_byte = mau_io.dmem_rdata[15:8];
      2'd2:    ld_byte = mau_io.dmem_rdata[23:16];
      2'd3:    ld_byte = mau_io.dmem_rdata[31:24];
      default: ld_byte = mau_io.dmem_rdata[7:0];
    endcase
    ld_half = addr_lo_q[1] ? mau_io.dmem_rdata[31:16] : mau_io.dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = mau_io.dmem_rdata;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dmem_we_d     = dmem_we_q;
    dmem_addr_d   = dmem_addr_q;
    dmem_wdata_d  = dmem_wdata_q;
    dmem_wstrb_d  = dmem_wstrb_q;
    wb_en_d       = wb_en_q;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    fault_cause_d = fault_cause_q;
    funct3_d      = funct3_q;
    addr_lo_d     = addr_lo_q;

    unique case (state_q)
      StIdle: begin
        if (mau_io.ex_valid) begin
          wb_rd_d   = mau_io.rd;
          funct3_d  = mau_io.funct3;
          addr_lo_d = mau_io.mem_addr[1:0];
          if (is_load || is_store) begin
            if (!width_ok) begin
              state_d       = StFault;
              fault_cause_d = CauseIllegal;
            end else if (misaligned) begin
              state_d       = StFault;
              fault_cause_d = CauseMisaligned;
            end else begin
              state_d      = StReq;
              cnt_d        = '0;
              dmem_we_d    = is_store;
              dmem_addr_d  = {mau_io.mem_addr[31:2], 2'b00};
              dmem_wstrb_d = is_store ? st_strb : 4'b0000;
              dmem_wdata_d = st_data;
            end
          end else begin
            state_d   = StWb;
            wb_data_d = mau_io.alu_result;
            wb_en_d   = (mau_io.rd != 5'd0) && (mau_io.opcode != OpBranch);
          end
        end
      end
      StReq: begin
        if (mau_io.dmem_ack) begin
          state_d = StWb;
          if (dmem_we_q) begin
            wb_en_d = 1'b0;
          end else begin
            wb_en_d   = (wb_rd_q != 5'd0);
            wb_data_d = ld_data;
          end
        end else if (cnt_q == CntLast) begin
          state_d       = StFault;
          fault_cause_d = CauseTimeout;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWb:    state_d = StIdle;
      StFault: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      dmem_we_q     <= 1'b0;
      dmem_addr_q   <= '0;
      dmem_wdata_q  <= '0;
      dmem_wstrb_q  <= '0;
      wb_en_q       <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      fault_cause_q <= '0;
      funct3_q      <= '0;
      addr_lo_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dmem_we_q     <= dmem_we_d;
      dmem_addr_q   <= dmem_addr_d;
      dmem_wdata_q  <= dmem_wdata_d;
      dmem_wstrb_q  <= dmem_wstrb_d;
      wb_en_q       <= wb_en_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      fault_cause_q <= fault_cause_d;
      funct3_q      <= funct3_d;
      addr_lo_q     <= addr_lo_d;
    end
  end

  assign mau_io.ex_ready    = (state_q == StIdle);
  assign mau_io.dmem_req    = (state_q == StReq);
  assign mau_io.dmem_we     = dmem_we_q;
  assign mau_io.dmem_addr   = dmem_addr_q;
  assign mau_io.dmem_wdata  = dmem_wdata_q;
  assign mau_io.dmem_wstrb  = dmem_wstrb_q;
  assign mau_io.wb_valid    = (state_q == StWb);
  assign mau_io.wb_en       = wb_en_q & (state_q == StWb);
  assign mau_io.wb_rd       = wb_rd_q;
  assign mau_io.wb_data     = wb_data_q;
  assign mau_io.fault       = (state_q == StFault);
  assign mau_io.fault_cause = fault_cause_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed and random execute results
// compared against a behavioural model of the load/store/writeback rules.
module tb_mem_access_unit;

  localparam int unsigned To = 16;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpAdd    = 7'b0110011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mem_access_unit_if mau_if ();

  mem_access_unit #(.TIMEOUT(To)) dut (
    .clk    (clk),
    .rst    (rst),
    .mau_io (mau_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          fault;
    logic [1:0]  cause;
    bit          is_mem;
    logic        we;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wb_en;
    logic [31:0] wb_data;
  } exp_t;

  typedef struct {
    logic        ready_before;
    logic        pulse_before;
    logic [1:0]  cause_before;
    int          req_cycles;
    bit          req_stable;
    logic        we;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    bit          got_wb;
    bit          got_fault;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  cause;
    int          lat;
  } obs_t;

  // Reference: what a retire/fault should look like for one execute result.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] sd,
                                 input logic [31:0] alu, input logic [4:0] rd,
                                 input logic [31:0] rdata);
    exp_t        e;
    int          size;
    int          off;
    bit          legal;
    logic [63:0] val;
    e = '{default: 0};
    if (op != OpLoad && op != OpStore) begin
      e.wb_en   = (rd != 0) && (op != OpBranch);
      e.wb_data = alu;
      return e;
    end
    e.is_mem = 1;
    if (op == OpLoad) legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    else              legal = (f3 <= 2);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (!legal) begin
      e.fault = 1; e.cause = 2'b11; return e;
    end
    if (addr % size != 0) begin
      e.fault = 1; e.cause = 2'b01; return e;
    end
    off     = int'(addr % 4);
    e.daddr = addr - 32'(off);
    e.we    = (op == OpStore);
    if (e.we) begin
      e.wstrb = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = sd[8*(i % size) +: 8];
      e.wb_en = 0;
    end else begin
      e.wstrb = 4'b0000;
      val = 64'(rdata >> (8 * off)) % (64'd1 << (8 * size));
      if (!f3[2] && size < 4 && val >= (64'd1 << (8 * size - 1))) val = val - (64'd1 << (8 * size));
      e.wb_data = val[31:0];
      e.wb_en   = (rd != 0);
    end
    return e;
  endfunction

  // Presents one execute result, plays the memory (ack after waitc wait cycles,
  // never if waitc < 0) and records what the unit did, up to a bounded window.
  task automatic drive_txn(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sd, input logic [31:0] alu, input logic [4:0] rd,
                           input logic [31:0] rdata, input int waitc, output obs_t o);
    bit done;
    o = '{default: 0};
    o.req_stable = 1;
    @(negedge clk);
    o.ready_before = mau_if.ex_ready;
    o.pulse_before = mau_if.wb_valid | mau_if.fault;
    o.cause_before = mau_if.fault_cause;
    mau_if.ex_valid   = 1'b1;
    mau_if.opcode     = op;
    mau_if.funct3     = f3;
    mau_if.mem_addr   = addr;
    mau_if.store_data = sd;
    mau_if.alu_result = alu;
    mau_if.rd         = rd;
    @(posedge clk);
    #1;
    done = 0;
    for (int c = 1; c <= 64 && !done; c++) begin
      // Junk on the execute side; must be ignored outside IDLE.
      mau_if.ex_valid   = 1'($urandom);
      mau_if.opcode     = 7'($urandom);
      mau_if.funct3     = 3'($urandom);
      mau_if.mem_addr   = $urandom;
      mau_if.alu_result = $urandom;
      mau_if.rd         = 5'($urandom);
      @(negedge clk);
      if (mau_if.dmem_req === 1'b1) begin
        if (o.req_cycles == 0) begin
          o.we = mau_if.dmem_we; o.daddr = mau_if.dmem_addr;
          o.wdata = mau_if.dmem_wdata; o.wstrb = mau_if.dmem_wstrb;
        end else if (o.we !== mau_if.dmem_we || o.daddr !== mau_if.dmem_addr ||
                     o.wdata !== mau_if.dmem_wdata || o.wstrb !== mau_if.dmem_wstrb) begin
          o.req_stable = 0;
        end
        o.req_cycles++;
        if (o.req_cycles == waitc + 1) begin
          mau_if.dmem_ack = 1'b1; mau_if.dmem_rdata = rdata;
        end
      end else begin
        mau_if.dmem_ack = 1'($urandom);
      end
      if (mau_if.wb_valid === 1'b1) begin
        o.got_wb = 1; o.wb_en = mau_if.wb_en; o.wb_rd = mau_if.wb_rd;
        o.wb_data = mau_if.wb_data; o.lat = c; done = 1;
      end
      if (mau_if.fault === 1'b1) begin
        o.got_fault = 1; o.cause = mau_if.fault_cause; o.lat = c; done = 1;
      end
      @(posedge clk);
      #1;
      mau_if.dmem_ack   = 1'b0;
      mau_if.dmem_rdata = $urandom;
    end
    mau_if.ex_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [127:0] outs;
    mau_if.ex_valid = 1'b1; mau_if.opcode = OpLoad; mau_if.funct3 = 3'b010;
    mau_if.mem_addr = 32'h100; mau_if.dmem_ack = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    outs = {mau_if.dmem_req, mau_if.dmem_we, mau_if.dmem_addr, mau_if.dmem_wdata,
            mau_if.dmem_wstrb, mau_if.wb_valid, mau_if.wb_en, mau_if.wb_rd, mau_if.wb_data,
            mau_if.fault, mau_if.fault_cause};
    checks++;
    if (mau_if.ex_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", mau_if.ex_ready);
    end
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", outs);
    end
    rst = 1'b0; mau_if.ex_valid = 1'b0; mau_if.dmem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (mau_if.dmem_req !== 1'b0 || mau_if.wb_valid !== 1'b0 || mau_if.fault !== 1'b0) begin
      errors++; $display("FAIL idle_quiet got req=%b wb=%b fault=%b want 0 0 0",
                         mau_if.dmem_req, mau_if.wb_valid, mau_if.fault);
    end
  endtask

  task automatic test_alu();
    obs_t o; exp_t e;
    logic [6:0] op; logic [31:0] alu; logic [4:0] rd;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin op = OpAdd; alu = 32'h7; rd = 5'd5; end
      else begin
        case ($urandom_range(3))
          0: op = OpAdd;
          1: op = 7'b0010011;
          2: op = OpBranch;
          default: op = 7'b0110111;
        endcase
        alu = $urandom; rd = (i == 1) ? 5'd0 : 5'($urandom);
      end
      e = model(op, 3'b000, 32'h0, 32'h0, alu, rd, 32'h0);
      drive_txn(op, 3'($urandom), $urandom, $urandom, alu, rd, 32'h0, 0, o);
      checks++;
      if (o.ready_before !== 1'b1 || o.pulse_before !== 1'b0) begin
        errors++; $display("FAIL alu_ready got rdy=%b pulse=%b want 1 0", o.ready_before, o.pulse_before);
      end
      checks++;
      if (!o.got_wb || o.lat != 1 || o.req_cycles != 0) begin
        errors++; $display("FAIL alu_timing got wb=%0d lat=%0d req=%0d want 1 1 0",
                           o.got_wb, o.lat, o.req_cycles);
      end
      checks++;
      if (o.wb_en !== e.wb_en || o.wb_rd !== rd || o.wb_data !== e.wb_data) begin
        errors++; $display("FAIL alu_wb got en=%b rd=%0d data=%h want %b %0d %h",
                           o.wb_en, o.wb_rd, o.wb_data, e.wb_en, rd, e.wb_data);
      end
    end
  endtask

  task automatic test_loads();
    obs_t o; exp_t e;
    logic [2:0] f3; logic [31:0] addr, rdata; logic [4:0] rd; int waitc;
    for (int i = 0; i < 14; i++) begin
      if (i < 2) begin
        f3 = (i == 0) ? 3'b000 : 3'b100; addr = 32'h1003; rdata = 32'h80AA_BBCC;
        rd = 5'd9; waitc = 2;
      end else if (i == 2) begin
        f3 = 3'b010; addr = 32'h40; rdata = 32'hDEAD_BEEF; rd = 5'd0; waitc = 0;
      end else begin
        case ($urandom_range(4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
        addr = $urandom;
        if (f3[1:0] == 2'b01) addr[0] = 1'b0;
        if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
        rdata = $urandom; rd = 5'($urandom); waitc = $urandom_range(3);
      end
      e = model(OpLoad, f3, addr, 32'h0, 32'h0, rd, rdata);
      drive_txn(OpLoad, f3, addr, $urandom, $urandom, rd, rdata, waitc, o);
      checks++;
      if (o.ready_before !== 1'b1 || o.req_cycles != waitc + 1 || !o.req_stable) begin
        errors++; $display("FAIL ld_req got rdy=%b req=%0d stable=%0d want 1 %0d 1",
                           o.ready_before, o.req_cycles, o.req_stable, waitc + 1);
      end
      checks++;
      if (o.daddr !== e.daddr || o.we !== 1'b0 || o.wstrb !== 4'b0000) begin
        errors++; $display("FAIL ld_bus got addr=%h we=%b strb=%b want %h 0 0000",
                           o.daddr, o.we, o.wstrb, e.daddr);
      end
      checks++;
      if (!o.got_wb || o.got_fault || o.lat != waitc + 2) begin
        errors++; $display("FAIL ld_timing got wb=%0d fault=%0d lat=%0d want 1 0 %0d",
                           o.got_wb, o.got_fault, o.lat, waitc + 2);
      end
      checks++;
      if (o.wb_en !== e.wb_en || o.wb_rd !== rd || o.wb_data !== e.wb_data) begin
        errors++; $display("FAIL ld_wb got en=%b rd=%0d data=%h want %b %0d %h",
                           o.wb_en, o.wb_rd, o.wb_data, e.wb_en, rd, e.wb_data);
      end
    end
  endtask

  task automatic test_stores();
    obs_t o; exp_t e;
    logic [2:0] f3; logic [31:0] addr, sd; int waitc;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin
        f3 = 3'b001; addr = 32'h2002; sd = 32'h1234_5678; waitc = 1;
      end else begin
        f3 = 3'($urandom_range(2)); addr = $urandom; sd = $urandom; waitc = $urandom_range(3);
        if (f3 == 3'b001) addr[0] = 1'b0;
        if (f3 == 3'b010) addr[1:0] = 2'b00;
      end
      e = model(OpStore, f3, addr, sd, 32'h0, 5'd3, 32'h0);
      drive_txn(OpStore, f3, addr, sd, $urandom, 5'd3, $urandom, waitc, o);
      checks++;
      if (o.req_cycles != waitc + 1 || !o.req_stable || o.daddr !== e.daddr || o.we !== 1'b1) begin
        errors++; $display("FAIL st_req got req=%0d stable=%0d addr=%h we=%b want %0d 1 %h 1",
                           o.req_cycles, o.req_stable, o.daddr, o.we, waitc + 1, e.daddr);
      end
      checks++;
      if (o.wstrb !== e.wstrb || o.wdata !== e.wdata) begin
        errors++; $display("FAIL st_lanes got strb=%b data=%h want %b %h",
                           o.wstrb, o.wdata, e.wstrb, e.wdata);
      end
      checks++;
      if (!o.got_wb || o.wb_en !== 1'b0 || o.lat != waitc + 2) begin
        errors++; $display("FAIL st_wb got wb=%0d en=%b lat=%0d want 1 0 %0d",
                           o.got_wb, o.wb_en, o.lat, waitc + 2);
      end
    end
  endtask

  task automatic test_faults();
    obs_t o, o2; exp_t e;
    logic [6:0] op; logic [2:0] f3; logic [31:0] addr;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0: begin op = OpLoad;  f3 = 3'b010; addr = 32'h6;    end
        1: begin op = OpLoad;  f3 = 3'b011; addr = 32'h100;  end
        2: begin op = OpStore; f3 = 3'b100; addr = 32'h100;  end
        3: begin op = OpLoad;  f3 = 3'b101; addr = 32'h1001; end
        4: begin op = OpStore; f3 = 3'b010; addr = 32'h2;    end
        default: begin
          op = ($urandom_range(1) == 0) ? OpLoad : OpStore;
          f3 = 3'($urandom);
          addr = $urandom | 32'h1;
          if (f3[1:0] == 2'b00 && ((op == OpLoad && f3 != 3'b110 && f3 != 3'b111) ||
                                   (op == OpStore && f3 == 3'b000))) f3 = 3'b110;
        end
      endcase
      e = model(op, f3, addr, 32'h0, 32'h0, 5'd4, 32'h0);
      drive_txn(op, f3, addr, $urandom, $urandom, 5'd4, $urandom, 0, o);
      checks++;
      if (!o.got_fault || o.cause !== e.cause || o.lat != 1) begin
        errors++; $display("FAIL flt_pulse got fault=%0d cause=%b lat=%0d want 1 %b 1",
                           o.got_fault, o.cause, o.lat, e.cause);
      end
      checks++;
      if (o.req_cycles != 0 || o.got_wb) begin
        errors++; $display("FAIL flt_quiet got req=%0d wb=%0d want 0 0", o.req_cycles, o.got_wb);
      end
      drive_txn(OpAdd, 3'b000, 32'h0, 32'h0, 32'h55, 5'd1, 32'h0, 0, o2);
      checks++;
      if (o2.ready_before !== 1'b1 || o2.pulse_before !== 1'b0 || o2.cause_before !== e.cause) begin
        errors++; $display("FAIL flt_after got rdy=%b pulse=%b cause=%b want 1 0 %b",
                           o2.ready_before, o2.pulse_before, o2.cause_before, e.cause);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t o, o2;
    drive_txn(OpLoad, 3'b010, 32'h300, 32'h0, 32'h0, 5'd6, 32'h0, -1, o);
    checks++;
    if (o.req_cycles != To || !o.req_stable) begin
      errors++; $display("FAIL to_req got req=%0d stable=%0d want %0d 1", o.req_cycles, o.req_stable, To);
    end
    checks++;
    if (!o.got_fault || o.got_wb || o.cause !== 2'b10 || o.lat != To + 1) begin
      errors++; $display("FAIL to_fault got fault=%0d wb=%0d cause=%b lat=%0d want 1 0 10 %0d",
                         o.got_fault, o.got_wb, o.cause, o.lat, To + 1);
    end
    drive_txn(OpAdd, 3'b000, 32'h0, 32'h0, 32'h9, 5'd2, 32'h0, 0, o2);
    checks++;
    if (o2.ready_before !== 1'b1 || o2.pulse_before !== 1'b0 || !o2.got_wb) begin
      errors++; $display("FAIL to_recover got rdy=%b pulse=%b wb=%0d want 1 0 1",
                         o2.ready_before, o2.pulse_before, o2.got_wb);
    end
  endtask

  task automatic test_reset_in_req();
    int events;
    @(negedge clk);
    mau_if.ex_valid = 1'b1; mau_if.opcode = OpLoad; mau_if.funct3 = 3'b010;
    mau_if.mem_addr = 32'h500; mau_if.rd = 5'd7;
    @(posedge clk);
    #1 mau_if.ex_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mau_if.dmem_req !== 1'b1) begin
      errors++; $display("FAIL rr_inreq got req=%b want 1", mau_if.dmem_req);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; mau_if.dmem_ack = 1'b1; mau_if.dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (mau_if.dmem_req !== 1'b0 || mau_if.ex_ready !== 1'b1) begin
      errors++; $display("FAIL rr_abort got req=%b rdy=%b want 0 1", mau_if.dmem_req, mau_if.ex_ready);
    end
    events = 0;
    for (int c = 0; c < 4; c++) begin
      if (mau_if.wb_valid !== 1'b0 || mau_if.fault !== 1'b0) events++;
      @(negedge clk);
    end
    checks++;
    if (events != 0) begin
      errors++; $display("FAIL rr_late_ack got %0d pulses want 0", events);
    end
    mau_if.dmem_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    obs_t o; exp_t e;
    logic [6:0] op; logic [2:0] f3; logic [31:0] addr, sd, alu, rdata; logic [4:0] rd;
    int waitc;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(5))
        0, 1: op = OpLoad;
        2, 3: op = OpStore;
        4: op = OpBranch;
        default: op = OpAdd;
      endcase
      f3 = 3'($urandom); addr = $urandom; sd = $urandom; alu = $urandom;
      rdata = $urandom; rd = 5'($urandom); waitc = $urandom_range(3);
      if ($urandom_range(3) != 0) addr[1:0] = 2'b00;
      e = model(op, f3, addr, sd, alu, rd, rdata);
      drive_txn(op, f3, addr, sd, alu, rd, rdata, waitc, o);
      checks++;
      if (o.ready_before !== 1'b1 || o.pulse_before !== 1'b0) begin
        errors++; $display("FAIL b2b_ready got rdy=%b pulse=%b want 1 0", o.ready_before, o.pulse_before);
      end
      if (e.fault) begin
        checks++;
        if (!o.got_fault || o.cause !== e.cause || o.req_cycles != 0 || o.got_wb) begin
          errors++; $display("FAIL b2b_fault got fault=%0d cause=%b req=%0d wb=%0d want 1 %b 0 0",
                             o.got_fault, o.cause, o.req_cycles, o.got_wb, e.cause);
        end
      end else begin
        checks++;
        if (!o.got_wb || o.got_fault || o.wb_en !== e.wb_en || o.wb_rd !== rd) begin
          errors++; $display("FAIL b2b_wb got wb=%0d fault=%0d en=%b rd=%0d want 1 0 %b %0d",
                             o.got_wb, o.got_fault, o.wb_en, o.wb_rd, e.wb_en, rd);
        end
        checks++;
        if ((!e.is_mem || !e.we) && o.wb_data !== e.wb_data) begin
          errors++; $display("FAIL b2b_data got %h want %h", o.wb_data, e.wb_data);
        end
        if (e.is_mem) begin
          checks++;
          if (o.daddr !== e.daddr || o.we !== e.we || o.wstrb !== e.wstrb ||
              (e.we && o.wdata !== e.wdata) || o.lat != waitc + 2) begin
            errors++; $display("FAIL b2b_bus got a=%h we=%b s=%b d=%h lat=%0d want %h %b %b %h %0d",
                               o.daddr, o.we, o.wstrb, o.wdata, o.lat,
                               e.daddr, e.we, e.wstrb, e.wdata, waitc + 2);
          end
        end
      end
    end
  endtask

  initial begin
    mau_if.ex_valid   = 1'b0;
    mau_if.opcode     = '0;
    mau_if.funct3     = '0;
    mau_if.alu_result = '0;
    mau_if.mem_addr   = '0;
    mau_if.store_data = '0;
    mau_if.rd         = '0;
    mau_if.dmem_ack   = 1'b0;
    mau_if.dmem_rdata = '0;
    test_reset();
    test_alu();
    test_loads();
    test_stores();
    test_reset_in_req();
    test_faults();
    test_timeout();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory/writeback-side consumer of the execute stage results: alu_result, mem_addr, rd, opcode, plus rs2 data for stores.
- Non-memory instructions are passed straight to register writeback.
- LOAD/STORE operations run a req/ack handshake with data memory, with byte-lane steering and load sign/zero extension.
- Misaligned accesses, illegal widths and memory timeouts are reported on a fault output.

Parameters:
TIMEOUT, 16, max REQ cycles waiting for dmem_ack before a timeout fault (>=1)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
ex_valid  in  1  execute result valid this cycle
ex_ready  out  1  unit can accept a new execute result
opcode  in  7  instruction opcode (RV32I encodings)
funct3  in  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
alu_result  in  32  ALU result for non-memory instructions
mem_addr  in  32  byte address for LOAD/STORE
store_data  in  32  rs2 value for STORE
rd  in  5  destination register
dmem_req  out  1  memory request valid
dmem_we  out  1  1 = write, 0 = read
dmem_addr  out  32  word-aligned address (mem_addr[31:2], 2'b00)
dmem_wdata  out  32  lane-replicated store data
dmem_wstrb  out  4  byte enables for writes (0000 on reads)
dmem_ack  in  1  memory completed request; rdata valid same cycle
dmem_rdata  in  32  read word
wb_valid  out  1  one-cycle retire pulse
wb_en  out  1  register-file write enable (qualified by wb_valid)
wb_rd  out  5  writeback register
wb_data  out  32  writeback value
fault  out  1  one-cycle exception pulse
fault_cause  out  2  01 misaligned, 10 timeout, 11 illegal width; held until next fault

Behaviour:
- Reset values: state IDLE, ex_ready=1, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_wstrb=0, wb_valid=0, wb_en=0, wb_rd=0, wb_data=0, fault=0, fault_cause=00, timeout counter=0.
- States: IDLE, REQ, WB, FAULT. ex_ready=1 only in IDLE; ex_valid is ignored outside IDLE.
- IDLE accepts on ex_valid=1 and registers all inputs. Next state is chosen as follows:
  - opcode 0000011 (LOAD) or 0100011 (STORE):
    - funct3 illegal (load 011/110/111; store any value other than 000/001/010) -> FAULT, cause 11.
    - H access with addr[0]=1, or W access with addr[1:0]!=0 -> FAULT, cause 01.
    - otherwise -> REQ.
  - any other opcode -> WB with wb_data=alu_result.
- Non-memory wb_en: wb_en = (rd!=0) and opcode not 1100011 (BRANCH).
- REQ state:
  - dmem_req=1 from the first REQ cycle.
  - addr/we/wdata/wstrb are stable until ack is seen.
  - Counter increments each REQ cycle without ack.
  - On ack: store -> WB, wb_en=0; load -> WB with the extracted data, wb_en=(rd!=0).
  - Counter reaching TIMEOUT with no ack -> FAULT, cause 10; dmem_req drops next cycle.
- Store lanes:
  - SB: wstrb=0001<<addr[1:0], wdata={4{byte}}.
  - SH: wstrb=0011<<{addr[1],1'b0}, wdata={2{half}}.
  - SW: wstrb=1111, wdata=store_data.
- Load extract: select the byte/half at addr[1:0] from dmem_rdata. B/H sign-extend; BU/HU zero-extend; W passes through.
- WB state: wb_valid=1 for exactly one cycle, then IDLE.
- FAULT state: fault=1 for exactly one cycle, wb_valid=0, no dmem access, then IDLE.
- Latency:
  - Non-memory: accepted edge N -> wb_valid during cycle N+1.
  - Memory with ack in the first REQ cycle: dmem_req in N+1, wb_valid in N+2.
  - Each wait cycle adds 1.
- ack outside REQ is ignored.
- rst in any state returns to IDLE at the next edge: dmem_req deasserts, no wb/fault pulse, and a pending transaction is abandoned.

Test Plan:
- ADD opcode 0110011, alu_result=0x0000_0007, rd=5 -> next cycle wb_valid=1, wb_en=1, wb_rd=5, wb_data=0x7; no dmem_req.
- LB mem_addr=0x1003, dmem_rdata=0x80AA_BBCC, ack after 2 wait cycles -> dmem_addr=0x1000, wstrb=0000. Result: wb_data=0xFFFF_FF80 (sign-extended byte lane 3). LBU on the same access -> wb_data=0x0000_0080.
- SH mem_addr=0x2002, store_data=0x1234_5678 -> dmem_we=1, wstrb=1100, wdata=0x5678_5678. On ack: wb_valid=1, wb_en=0.
- LW mem_addr=0x0000_0006 -> fault=1, cause=01; dmem_req never asserted. funct3=011 load -> fault, cause=11.
- LW with dmem_ack held 0, TIMEOUT=16 -> dmem_req high for 16 cycles, then fault=1, cause=10, back in IDLE with ex_ready=1.
- Load with rd=0 -> wb_valid=1, wb_en=0. rst asserted during REQ -> next cycle dmem_req=0, ex_ready=1; a late ack causes no wb_valid.
